jtag_chain_hub: RTL and testbench

- Parametrised successor to the single-chain JTAG user IP core.
- Hosts N_CHAINS independent user data registers (DRs) behind the ECP5 JTAGG primitive, each with its own JCE and JRTI enables.
- Per chain, runs the capture/shift/update protocol, optionally validates shift length, and exposes update data, strobes, error flags and run-test-idle pulses.
- Sits between the JTAGG primitive and the chain-specific back-ends: pingpong buffer, DMA control, status.

---
 rtl/jtag_chain_hub_pkg.sv | 25 ++
 rtl/jtag_chain_hub_if.sv | 31 +++
 rtl/jtag_user_chain.sv | 98 +++++++++
 rtl/jtag_chain_hub.sv | 41 ++++
 tb/tb_jtag_chain_hub.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_chain_hub_pkg.sv
// jtag_hub_pkg: shared types and helpers for the JTAG user-chain hub.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: chain FSM state enum, counter-width helper, TAP condition encodings.
package jtag_hub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
  } chain_state_t;

  // The counter must hold DR_WIDTH+1 so an over-long shift stays distinguishable
  // from an exact one instead of wrapping back to a valid count.
  function automatic int cnt_width(input int dr_width);
    return $clog2(dr_width + 2);
  endfunction

  // TAP condition encodings on {JSHIFT, JUPDATE}. Capture and shift also need
  // the chain to be the selected one; update applies to every chain.
  localparam logic [1:0] TAP_CAPTURE = 2'b00;
  localparam logic [1:0] TAP_SHIFT   = 2'b10;
  localparam logic [1:0] TAP_UPDATE  = 2'b01;

endpackage

// File: rtl/jtag_chain_hub_if.sv
// jtag_chain_hub_if: bundle between the JTAGG primitive side and the chain hub.
// Latency: n/a (wires only).
// Backpressure: none; the JTAG clock paces every transfer.
// Modports: master = JTAGG/back-end side (drives TAP signals, capture data);
//           slave  = hub (drives JTD, update data, strobes, flags).
interface jtag_chain_hub_if #(
  parameter int N_CHAINS = 2,
  parameter int DR_WIDTH = 32
);
  logic                         JTDI;
  logic                         JSHIFT;
  logic                         JUPDATE;
  logic [N_CHAINS-1:0]          JCE;
  logic [N_CHAINS-1:0]          JRTI;
  logic [N_CHAINS-1:0]          JTD;
  logic [N_CHAINS*DR_WIDTH-1:0] capture_data;
  logic [N_CHAINS*DR_WIDTH-1:0] update_data;
  logic [N_CHAINS-1:0]          update_valid;
  logic [N_CHAINS-1:0]          len_error;
  logic [N_CHAINS-1:0]          rti_pulse;

  modport master (
    output JTDI, JSHIFT, JUPDATE, JCE, JRTI, capture_data,
    input  JTD, update_data, update_valid, len_error, rti_pulse
  );

  modport slave (
    input  JTDI, JSHIFT, JUPDATE, JCE, JRTI, capture_data,
    output JTD, update_data, update_valid, len_error, rti_pulse
  );
endinterface

// File: rtl/jtag_user_chain.sv
// jtag_user_chain: one user DR with capture/shift/update FSM, length check and RTI edge detect.
// Latency: upd_dat/upd_vld one JTCK after Update-DR is sampled; rti_pulse one JTCK after rti rises.
// Backpressure: none; every JTCK step is accepted unconditionally.
// Ports: clk/rst_n; act (chain selected by JCE priority), tdi, shift_st, update_st, rti,
//        cap_dat in; td, upd_dat, upd_vld, len_err, rti_pulse out.
module jtag_user_chain
  import jtag_hub_pkg::*;
#(
  parameter int DR_WIDTH   = 32,
  parameter bit STRICT_LEN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                act,
  input  logic                tdi,
  input  logic                shift_st,
  input  logic                update_st,
  input  logic                rti,
  input  logic [DR_WIDTH-1:0] cap_dat,
  output logic                td,
  output logic [DR_WIDTH-1:0] upd_dat,
  output logic                upd_vld,
  output logic                len_err,
  output logic                rti_pulse
);
  localparam int CW = cnt_width(DR_WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DR_WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DR_WIDTH + 1);

  chain_state_t        state, state_nxt;
  logic [DR_WIDTH-1:0] dr;
  logic [CW-1:0]       cnt;
  logic                rti_q;
  logic [1:0]          tap;
  logic                do_cap, do_shift, do_commit, do_err;

  assign tap = {shift_st, update_st};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (act && tap == TAP_CAPTURE) begin
      state_nxt = ARMED;
    end else if (act && tap == TAP_SHIFT) begin
      if (state != IDLE) state_nxt = SHIFT;
    end else if (tap == TAP_UPDATE) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    do_cap    = act && tap == TAP_CAPTURE;
    // A shift without a preceding capture is ignored entirely.
    do_shift  = act && tap == TAP_SHIFT && state != IDLE;
    do_commit = 1'b0;
    do_err    = 1'b0;
    if (tap == TAP_UPDATE && state == SHIFT) begin
      if (!STRICT_LEN || cnt == CNT_FULL) do_commit = 1'b1;
      else                                do_err    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dr        <= '0;
      cnt       <= '0;
      upd_dat   <= '0;
      upd_vld   <= 1'b0;
      len_err   <= 1'b0;
      rti_q     <= 1'b0;
      rti_pulse <= 1'b0;
    end else begin
      upd_vld   <= do_commit;
      rti_q     <= rti;
      rti_pulse <= rti & ~rti_q;
      if (do_cap) begin
        dr  <= cap_dat;
        cnt <= '0;
      end else if (do_shift) begin
        dr <= {tdi, dr[DR_WIDTH-1:1]};
        if (cnt != CNT_SAT) cnt <= cnt + CW'(1);
      end
      if (do_commit) begin
        upd_dat <= dr;
        len_err <= 1'b0;
      end else if (do_err) begin
        len_err <= 1'b1;
      end
    end
  end

  // TDO comes straight from the DR flop, so there is no path from tdi.
  assign td = dr[0];
endmodule

// File: rtl/jtag_chain_hub.sv
// jtag_chain_hub: N_CHAINS user DRs behind the JTAGG primitive, lowest-JCE-wins selection.
// Latency: update_valid/update_data one JTCK after JUPDATE; rti_pulse one JTCK after JRTI rises.
// Backpressure: none; the TAP controller paces all traffic.
// Ports: JTCK (only clock), JRSTN (async active-low reset), bus (slave modport of jtag_chain_hub_if).
module jtag_chain_hub
  import jtag_hub_pkg::*;
#(
  parameter int N_CHAINS   = 2,
  parameter int DR_WIDTH   = 32,
  parameter bit STRICT_LEN = 1'b1
) (
  input  logic            JTCK,
  input  logic            JRSTN,
  jtag_chain_hub_if.slave bus
);
  logic [N_CHAINS-1:0] sel_oh;

  // Isolate the lowest set JCE bit; other asserted enables are ignored.
  assign sel_oh = bus.JCE & (~bus.JCE + N_CHAINS'(1));

  for (genvar i = 0; i < N_CHAINS; i++) begin : g_chain
    jtag_user_chain #(
      .DR_WIDTH   (DR_WIDTH),
      .STRICT_LEN (STRICT_LEN)
    ) u_chain (
      .clk       (JTCK),
      .rst_n     (JRSTN),
      .act       (sel_oh[i]),
      .tdi       (bus.JTDI),
      .shift_st  (bus.JSHIFT),
      .update_st (bus.JUPDATE),
      .rti       (bus.JRTI[i]),
      .cap_dat   (bus.capture_data[i*DR_WIDTH +: DR_WIDTH]),
      .td        (bus.JTD[i]),
      .upd_dat   (bus.update_data[i*DR_WIDTH +: DR_WIDTH]),
      .upd_vld   (bus.update_valid[i]),
      .len_err   (bus.len_error[i]),
      .rti_pulse (bus.rti_pulse[i])
    );
  end
endmodule

// File: tb/tb_jtag_chain_hub.sv
// tb_jtag_chain_hub: drives a strict-length and a lax-length hub with identical stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_jtag_chain_hub;
  localparam int N = 2;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          jtdi = 1'b0, jshift = 1'b0, jupdate = 1'b0;
  logic [N-1:0]  jce = '0, jrti = '0;
  logic [N*W-1:0] cap = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtag_chain_hub_if #(.N_CHAINS(N), .DR_WIDTH(W)) bs ();
  jtag_chain_hub_if #(.N_CHAINS(N), .DR_WIDTH(W)) bl ();

  assign bs.JTDI = jtdi;  assign bl.JTDI = jtdi;
  assign bs.JSHIFT = jshift;  assign bl.JSHIFT = jshift;
  assign bs.JUPDATE = jupdate;  assign bl.JUPDATE = jupdate;
  assign bs.JCE = jce;  assign bl.JCE = jce;
  assign bs.JRTI = jrti;  assign bl.JRTI = jrti;
  assign bs.capture_data = cap;  assign bl.capture_data = cap;

  jtag_chain_hub #(.N_CHAINS(N), .DR_WIDTH(W), .STRICT_LEN(1'b1)) dut_s (
    .JTCK(clk), .JRSTN(rst_n), .bus(bs));
  jtag_chain_hub #(.N_CHAINS(N), .DR_WIDTH(W), .STRICT_LEN(1'b0)) dut_l (
    .JTCK(clk), .JRSTN(rst_n), .bus(bl));

  // Reference model: n = bits shifted since capture, -1 when not captured.
  typedef struct {
    int          n;
    logic [W-1:0] dr;
    logic [W-1:0] upd;
    logic        uv, le, rq, rp;
  } mch_t;
  mch_t m [2][N];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) begin
        m[d][c].n = -1; m[d][c].dr = '0; m[d][c].upd = '0;
        m[d][c].uv = 0; m[d][c].le = 0; m[d][c].rq = 0; m[d][c].rp = 0;
      end
  endfunction

  function automatic void model_step();
    int sel;
    sel = -1;
    for (int i = N - 1; i >= 0; i--) if (jce[i]) sel = i;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) begin
        m[d][c].uv = 0;
        m[d][c].rp = jrti[c] & ~m[d][c].rq;
        m[d][c].rq = jrti[c];
        if (c == sel && !jshift && !jupdate) begin
          m[d][c].dr = cap[c*W +: W];
          m[d][c].n  = 0;
        end else if (c == sel && jshift && !jupdate) begin
          if (m[d][c].n >= 0) begin
            m[d][c].dr = {jtdi, m[d][c].dr[W-1:1]};
            m[d][c].n++;
          end
        end else if (jupdate && !jshift) begin
          if (m[d][c].n > 0) begin
            if (d == 1 || m[d][c].n == W) begin
              m[d][c].upd = m[d][c].dr; m[d][c].uv = 1; m[d][c].le = 0;
            end else begin
              m[d][c].le = 1;
            end
          end
          m[d][c].n = -1;
        end
      end
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] jtd, uv, le, rp, e_jtd, e_uv, e_le, e_rp;
      logic [N*W-1:0] ud, e_ud;
      if (d == 0) begin
        jtd = bs.JTD; uv = bs.update_valid; le = bs.len_error; rp = bs.rti_pulse; ud = bs.update_data;
      end else begin
        jtd = bl.JTD; uv = bl.update_valid; le = bl.len_error; rp = bl.rti_pulse; ud = bl.update_data;
      end
      for (int c = 0; c < N; c++) begin
        e_jtd[c] = m[d][c].dr[0]; e_uv[c] = m[d][c].uv; e_le[c] = m[d][c].le;
        e_rp[c] = m[d][c].rp; e_ud[c*W +: W] = m[d][c].upd;
      end
      check($sformatf("%s.d%0d.jtd", tag, d), 64'(jtd), 64'(e_jtd));
      check($sformatf("%s.d%0d.update_valid", tag, d), 64'(uv), 64'(e_uv));
      check($sformatf("%s.d%0d.len_error", tag, d), 64'(le), 64'(e_le));
      check($sformatf("%s.d%0d.rti_pulse", tag, d), 64'(rp), 64'(e_rp));
      check($sformatf("%s.d%0d.update_data", tag, d), 64'(ud), 64'(e_ud));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all("cyc");
  endtask

  task automatic idle(input int k);
    jce = '0; jshift = 0; jupdate = 0;
    repeat (k) tick();
  endtask

  task automatic capture(input logic [N-1:0] mask, input logic [N*W-1:0] v);
    cap = v; jce = mask; jshift = 0; jupdate = 0;
    tick();
  endtask

  task automatic shift_bits(input logic [N-1:0] mask, input logic [63:0] data, input int nb,
                            output logic [63:0] seen);
    seen = '0;
    jce = mask; jshift = 1; jupdate = 0;
    for (int k = 0; k < nb; k++) begin
      jtdi = data[k];
      seen[k] = bs.JTD[0];
      tick();
    end
    jshift = 0; jce = '0;
  endtask

  task automatic update();
    jce = '0; jshift = 0; jupdate = 1;
    tick();
    jupdate = 0;
  endtask

  typedef struct packed {
    logic [1:0] jce;
    logic       sh, up, tdi;
    logic [1:0] rti, e_jtd, e_uv, e_le, e_rp;
  } vec_t;
  vec_t vt [6];

  initial begin
    logic [63:0] seen, pat;
    vt[0] = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    vt[1] = '{2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
    vt[2] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    vt[3] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10};
    vt[4] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    vt[5] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};

    // Reset, then 20 idle cycles.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst_n = 1;
    idle(20);
    check("idle.update_data", 64'(bs.update_data), 64'h0);

    // Chain 0 capture/shift/update.
    capture(2'b01, {32'h0, 32'hA5A5A5A5});
    shift_bits(2'b01, 64'h12345678, 32, seen);
    check("c0.jtd_stream", seen, 64'hA5A5A5A5);
    update();
    check("c0.uv_pulse", 64'(bs.update_valid), 64'h1);
    check("c0.data", 64'(bs.update_data), 64'h12345678);
    idle(1);
    check("c0.uv_single", 64'(bs.update_valid), 64'h0);

    // Chain 1 short shift, then a full one.
    capture(2'b10, {32'h0F0F0F0F, 32'h0});
    shift_bits(2'b10, 64'h7FFFFFFF, 31, seen);
    update();
    check("c1.short.uv", 64'(bs.update_valid), 64'h0);
    check("c1.short.le", 64'(bs.len_error), 64'h2);
    check("c1.short.data", 64'(bs.update_data[63:32]), 64'h0);
    idle(1);
    capture(2'b10, {32'h0F0F0F0F, 32'h0});
    shift_bits(2'b10, 64'hDEADBEEF, 32, seen);
    update();
    check("c1.full.uv", 64'(bs.update_valid), 64'h2);
    check("c1.full.le", 64'(bs.len_error), 64'h0);
    check("c1.full.data", 64'(bs.update_data[63:32]), 64'hDEADBEEF);
    idle(1);

    // Over-long shift on chain 0: strict flags, lax keeps last 32 bits.
    pat = 64'h0123456789ABCDEF;
    capture(2'b01, {32'h0, 32'h55AA55AA});
    shift_bits(2'b01, pat, 40, seen);
    update();
    check("long.strict.uv", 64'(bs.update_valid), 64'h0);
    check("long.strict.le", 64'(bs.len_error), 64'h1);
    check("long.strict.data", 64'(bs.update_data[31:0]), 64'h12345678);
    check("long.lax.uv", 64'(bl.update_valid), 64'h1);
    check("long.lax.data", 64'(bl.update_data[31:0]), 64'(pat[39:8]));
    idle(1);

    // Both enables: chain 0 wins.
    capture(2'b11, {32'h11111111, 32'h22222222});
    shift_bits(2'b11, 64'hCAFEF00D, 32, seen);
    check("both.jtd_stream", seen, 64'h22222222);
    update();
    check("both.uv", 64'(bs.update_valid), 64'h1);
    check("both.data", 64'(bs.update_data), 64'hDEADBEEF_CAFEF00D);
    idle(1);

    // Asynchronous reset mid-shift.
    capture(2'b01, {32'h0, 32'hFFFFFFFF});
    shift_bits(2'b01, 64'hFFFF, 16, seen);
    #1 rst_n = 0;
    #1;
    model_reset();
    compare_all("arst");
    check("arst.data", 64'(bs.update_data), 64'h0);
    check("arst.jtd", 64'(bs.JTD), 64'h0);
    #1 rst_n = 1;
    update();
    check("arst.no_uv", 64'(bs.update_valid), 64'h0);
    idle(1);

    // Table vectors: capture/shift short, RTI edges, strict length error.
    cap = {32'h0, 32'h1};
    for (int i = 0; i < 6; i++) begin
      jce = vt[i].jce; jshift = vt[i].sh; jupdate = vt[i].up; jtdi = vt[i].tdi; jrti = vt[i].rti;
      tick();
      check($sformatf("vec%0d.jtd", i), 64'(bs.JTD), 64'(vt[i].e_jtd));
      check($sformatf("vec%0d.uv", i), 64'(bs.update_valid), 64'(vt[i].e_uv));
      check($sformatf("vec%0d.le", i), 64'(bs.len_error), 64'(vt[i].e_le));
      check($sformatf("vec%0d.rti", i), 64'(bs.rti_pulse), 64'(vt[i].e_rp));
    end

    // Randomised transactions against the model.
    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] mask;
      int len;
      mask = 2'($urandom_range(1, 3));
      case ($urandom_range(0, 4))
        0:       len = 31;
        1, 2:    len = 32;
        3:       len = 33 + int'($urandom_range(0, 7));
        default: len = int'($urandom_range(0, 40));
      endcase
      if ($urandom_range(0, 7) != 0) begin
        cap = {$urandom, $urandom}; jce = mask; jshift = 0; jupdate = 0; jrti = 2'($urandom);
        tick();
      end
      for (int k = 0; k < len; k++) begin
        jce = ($urandom_range(0, 9) == 0) ? 2'($urandom) : mask;
        jshift = 1; jtdi = 1'($urandom); jrti = 2'($urandom);
        tick();
      end
      jce = '0; jshift = 0; jupdate = 1; jrti = 2'($urandom);
      tick();
      jupdate = 0;
      repeat ($urandom_range(0, 2)) begin
        jrti = 2'($urandom);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
